mem_bus_initiator: RTL
======================

// Module: mem_bus_initiator
// PURPOSE
//   Bus master for the 8-bit rw/address/data memory-slave interface used by dff_with_memory-style blocks.
//   Accepts single-beat write and burst read commands on a valid/ready port, sequences slave signals.
//   Returns one response per beat on a valid/ready port.
//   Sits between test/control logic and any memory slave on the rw/address/data interface.
// PARAMETERS
//   ADDR_W      8   slave address width
//   DATA_W      8   slave data width
//   LEN_W       4   burst length field width; a read burst is cmd_len+1 beats (1..16)
//   RD_LATENCY  1   rising edges from mem_addr valid (mem_rw=0) to mem_rdata valid; legal 1..7
// PORTS
//   clk         in   1       single clock, rising edge
//   reset       in   1       asynchronous, active-low reset
//   cmd_valid   in   1       command offered
//   cmd_ready   out  1       command accepted when cmd_valid && cmd_ready at posedge
//   cmd_write   in   1       1 = write (single beat), 0 = read burst
//   cmd_addr    in   ADDR_W  start address
//   cmd_wdata   in   DATA_W  write data (ignored for reads)
//   cmd_len     in   LEN_W   read beats minus one (ignored for writes)
//   mem_rw      out  1       to slave: 1 = write, 0 = read
//   mem_addr    out  ADDR_W  to slave address_in
//   mem_wdata   out  DATA_W  to slave data_in
//   mem_rdata   in   DATA_W  from slave data_out
//   rsp_valid   out  1       response beat available
//   rsp_ready   in   1       response consumed when rsp_valid && rsp_ready at posedge
//   rsp_write   out  1       1 = write acknowledgement, 0 = read data beat
//   rsp_rdata   out  DATA_W  read data; 0 on write acknowledgements
//   rsp_last    out  1       final beat of the command
// BEHAVIOUR
//   Reset (async assert, sync release): state IDLE; cmd_ready=1; mem_rw=0; mem_addr=0; mem_wdata=0.
//     Also rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_last=0, all counters 0.
//   States: IDLE -> WRITE -> RESP -> IDLE (write); IDLE -> READ -> RESP -> READ|IDLE (read burst).
//   cmd_ready=1 only in IDLE; all other states stall the command port. No internal command queue.
//   IDLE: on accept, register addr, wdata, len, write; next state WRITE or READ.
//   WRITE: exactly one cycle with mem_rw=1, mem_addr=addr, mem_wdata=wdata.
//     Then RESP with rsp_write=1, rsp_rdata=0, rsp_last=1.
//   READ: mem_rw=0, mem_addr=current beat address; a wait counter counts RD_LATENCY edges.
//     On the RD_LATENCY-th edge, capture mem_rdata into rsp_rdata, set rsp_valid=1, go to RESP.
//   RESP: rsp_* held stable until rsp_ready; mem_rw=0; mem_addr holds the last value.
//     On handshake: if more beats remain, address += 1 modulo 2^ADDR_W (0xFF wraps to 0x00), beat count += 1, go to READ.
//     Otherwise go to IDLE with rsp_valid=0.
//   rsp_last=1 on the beat where beat count == len (or on a write ack).
//   Read throughput: one beat per RD_LATENCY+1 cycles when rsp_ready is held high.
//   mem_rw is never 1 outside WRITE; never more than one write strobe per write command.
//   Reset mid-command: the command is aborted and no response is issued; mem_rw drops to 0 immediately.
//   cmd_* are sampled only on the accept edge; later changes are ignored.
// STRUCTURE
//   Package mem_bus_pkg: ADDR_W/DATA_W/LEN_W defaults and typedef enum {IDLE, WRITE, READ, RESP} mib_state_t.
//   Sub-module mem_rd_wait_timer: loadable down-counter of RD_LATENCY; outputs done pulse on expiry.
//   The FSM, address/beat counters and response register stay in mem_bus_initiator.
// TESTING
//   T1 write 0xA5 @0x10: exactly 1 cycle mem_rw=1 addr=0x10 wdata=0xA5 -> rsp_write=1, rsp_last=1, rsp_rdata=0.
//   T2 read len=3 @0x20 after preloading 0x11,0x22,0x33,0x44 in the slave -> 4 beats 0x11..0x44 in order; rsp_last only on 4th.
//   T3 read len=2 @0xFE -> mem_addr sequence 0xFE, 0xFF, 0x00; three beats; no X on mem_addr.
//   T4 rsp_ready low 5 cycles mid-burst -> rsp_valid/rsp_rdata stable, mem_rw=0, cmd_ready=0; burst resumes intact.
//   T5 cmd_valid held high through a burst -> second command accepted only at the first IDLE cycle.
//     Verify with a scoreboard that the order is preserved.
//   T6 reset asserted during beat 2 of a len=7 read -> outputs at reset values asynchronously.
//     Next command after release completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus initiator.
// Holds the default bus widths, the read wait-counter width and the FSM state type.
package mem_bus_pkg;

   localparam int unsigned ADDR_W   = 8;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned LEN_W    = 4;
   // Wide enough for the largest legal read latency (7).
   localparam int unsigned RD_CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      RESP
   } mib_state_t;

endpackage

// File: rtl/mem_bus_initiator_if.sv
// Signal bundle for the memory-bus initiator: command port, slave rw/address/data port and
// response port.
// Modports:
//   master - the initiator's view: takes commands and mem_rdata, drives the slave and responses.
//   slave  - the surrounding logic's view (command source, memory slave, response sink).
interface mem_bus_initiator_if import mem_bus_pkg::*; #(
   parameter int unsigned ADDR_W = mem_bus_pkg::ADDR_W,
   parameter int unsigned DATA_W = mem_bus_pkg::DATA_W,
   parameter int unsigned LEN_W  = mem_bus_pkg::LEN_W
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [LEN_W-1:0]  cmd_len;

   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_write;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_last;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len, mem_rdata, rsp_ready,
      output cmd_ready, mem_rw, mem_addr, mem_wdata, rsp_valid, rsp_write, rsp_rdata, rsp_last
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len, mem_rdata, rsp_ready,
      input  cmd_ready, mem_rw, mem_addr, mem_wdata, rsp_valid, rsp_write, rsp_rdata, rsp_last
   );

endinterface

// File: rtl/mem_rd_wait_timer.sv
// Read wait timer: loadable down-counter of RD_LATENCY cycles.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   load   in  restart the count at RD_LATENCY
//   done   out one-cycle pulse in the cycle before the RD_LATENCY-th edge after load
// RD_LATENCY must lie in 1..7.
module mem_rd_wait_timer import mem_bus_pkg::*; #(
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic done
);

   logic [RD_CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = RD_CNT_W'(RD_LATENCY);
      end else if (count_q != '0) begin
         count_d = count_q - RD_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Count 1 means the next edge is the RD_LATENCY-th one since load.
   assign done = (count_q == RD_CNT_W'(1));

endmodule

// File: rtl/mem_bus_initiator.sv
// Bus master for an 8-bit rw/address/data memory slave.
// Accepts single-beat writes and burst reads on a valid/ready command port, drives the slave
// signals and returns one response per beat on a valid/ready response port.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    master modport of mem_bus_initiator_if (cmd_*, mem_*, rsp_*)
module mem_bus_initiator import mem_bus_pkg::*; #(
   parameter int unsigned ADDR_W     = mem_bus_pkg::ADDR_W,
   parameter int unsigned DATA_W     = mem_bus_pkg::DATA_W,
   parameter int unsigned LEN_W      = mem_bus_pkg::LEN_W,
   parameter int unsigned RD_LATENCY = 1
) (
   input logic                 clk,
   input logic                 reset,
   mem_bus_initiator_if.master bus
);

   mib_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  beat_q, beat_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_write_q, rsp_write_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_last_q, rsp_last_d;
   logic              timer_load;
   logic              timer_done;

   mem_rd_wait_timer #(
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_wait_timer (
      .clk   (clk),
      .reset (reset),
      .load  (timer_load),
      .done  (timer_done)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      len_d       = len_q;
      beat_d      = beat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_last_d  = rsp_last_q;
      timer_load  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               addr_d  = bus.cmd_addr;
               wdata_d = bus.cmd_wdata;
               len_d   = bus.cmd_len;
               beat_d  = '0;
               if (bus.cmd_write) begin
                  state_d = WRITE;
               end else begin
                  state_d    = READ;
                  timer_load = 1'b1;
               end
            end
         end
         WRITE: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_last_d  = 1'b1;
         end
         READ: begin
            if (timer_done) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b0;
               rsp_rdata_d = bus.mem_rdata;
               rsp_last_d  = (beat_q == len_q);
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (!rsp_write_q && (beat_q != len_q)) begin
                  // Next beat; the address wraps naturally at 2^ADDR_W.
                  addr_d     = addr_q + ADDR_W'(1);
                  beat_d     = beat_q + LEN_W'(1);
                  state_d    = READ;
                  timer_load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         len_q       <= '0;
         beat_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         len_q       <= len_d;
         beat_q      <= beat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_last_q  <= rsp_last_d;
      end
   end

   // Strobe decoded straight from state so a reset drops it without waiting for an edge.
   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.mem_rw    = (state_q == WRITE);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_write = rsp_write_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_last  = rsp_last_q;

endmodule
